// File: rtl/pipeline_ctrl.sv
// Hazard, forwarding and debug halt/step control for the in-order pipeline.
// Forwarding and stall/flush outputs are combinational from state and stage fields.
module pipeline_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic [4:0] ex_rs1,
  input  logic [4:0] ex_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_regwrite_en,
  input  logic       ex_wb_sel,
  input  logic [4:0] mem_rd,
  input  logic       mem_regwrite_en,
  input  logic [4:0] wb_rd,
  input  logic       wb_regwrite_en,
  input  logic [4:0] wbid_rd,
  input  logic       wbid_we,
  input  logic       pc_sel,
  input  logic       dbg_halt_req,
  input  logic       dbg_step_req,
  output logic       stall_if,
  output logic       stall_id,
  output logic       pc_en,
  output logic       flush_id,
  output logic       flush_ex,
  output logic [1:0] fwd_a_sel,
  output logic [1:0] fwd_b_sel,
  output logic       halted,
  output logic       step_done
);

  localparam int unsigned CNT_W_RAW = $clog2(DRAIN_CYCLES + 1);
  localparam int unsigned CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2,
    STEP   = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             step_flag_q, step_flag_d;
  logic             step_done_q, step_done_d;
  logic             luse_q, luse_d;
  logic             load_use;
  logic             luse_stall;

  // Nearest producing stage wins; x0 is never a forwarding source.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic [4:0] m_rd,  input logic m_we,
    input logic [4:0] w_rd,  input logic w_we,
    input logic [4:0] wi_rd, input logic wi_we
  );
    if (m_we && (m_rd != 5'd0) && (m_rd == src))
      return 2'b01;
    else if (w_we && (w_rd != 5'd0) && (w_rd == src))
      return 2'b10;
    else if (wi_we && (wi_rd != 5'd0) && (wi_rd == src))
      return 2'b11;
    else
      return 2'b00;
  endfunction

  assign load_use = ex_regwrite_en & ex_wb_sel & (ex_rd != 5'd0) &
                    ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

  // The bubble inserted by a load-use stall clears the hazard, so a stall never repeats back to back.
  assign luse_stall = load_use & ~pc_sel & ~luse_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      step_flag_q <= 1'b0;
      step_done_q <= 1'b0;
      luse_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      step_flag_q <= step_flag_d;
      step_done_q <= step_done_d;
      luse_q      <= luse_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    step_flag_d = step_flag_q;
    step_done_d = 1'b0;
    luse_d      = 1'b0;
    stall_if    = 1'b0;
    stall_id    = 1'b0;
    flush_id    = 1'b0;
    flush_ex    = 1'b0;
    halted      = 1'b0;
    fwd_a_sel   = fwd_sel(ex_rs1, mem_rd, mem_regwrite_en, wb_rd, wb_regwrite_en, wbid_rd, wbid_we);
    fwd_b_sel   = fwd_sel(ex_rs2, mem_rd, mem_regwrite_en, wb_rd, wb_regwrite_en, wbid_rd, wbid_we);

    case (state_q)
      RUN: begin
        if (luse_stall) begin
          stall_if = 1'b1;
          stall_id = 1'b1;
          flush_ex = 1'b1;
          luse_d   = 1'b1;
        end
        if (dbg_halt_req) begin
          state_d = DRAIN;
          cnt_d   = DRAIN_LOAD;
        end
      end
      DRAIN: begin
        stall_if = 1'b1;
        stall_id = 1'b1;
        flush_ex = 1'b1;
        if (cnt_q <= CNT_W'(1)) begin
          state_d     = HALTED;
          cnt_d       = '0;
          step_done_d = step_flag_q;
          step_flag_d = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      HALTED: begin
        stall_if = 1'b1;
        stall_id = 1'b1;
        flush_ex = 1'b1;
        halted   = 1'b1;
        if (!dbg_halt_req)
          state_d = RUN;
        else if (dbg_step_req)
          state_d = STEP;
      end
      STEP: begin
        if (luse_stall) begin
          stall_if = 1'b1;
          stall_id = 1'b1;
          flush_ex = 1'b1;
          luse_d   = 1'b1;
        end else begin
          state_d     = DRAIN;
          cnt_d       = DRAIN_LOAD;
          step_flag_d = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase

    // A resolved redirect is honoured in every state.
    if (pc_sel) begin
      flush_id = 1'b1;
      flush_ex = 1'b1;
    end

    if (!rst) begin
      stall_if  = 1'b0;
      stall_id  = 1'b0;
      flush_id  = 1'b0;
      flush_ex  = 1'b0;
      halted    = 1'b0;
      fwd_a_sel = 2'b00;
      fwd_b_sel = 2'b00;
    end
  end

  assign pc_en     = ~stall_if | pc_sel;
  assign step_done = step_done_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: forwarding vectors, hazard/debug sequences,
// and randomized RUN-state traffic against a reference model.
module tb_pipeline_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd, wbid_rd;
  logic       id_use_rs1, id_use_rs2, ex_regwrite_en, ex_wb_sel;
  logic       mem_regwrite_en, wb_regwrite_en, wbid_we;
  logic       pc_sel, dbg_halt_req, dbg_step_req;
  logic       stall_if, stall_id, pc_en, flush_id, flush_ex, halted, step_done;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic [10:0] act;

  int checks = 0;
  int failures = 0;

  // {stall_if, stall_id, pc_en, flush_id, flush_ex, fwd_a[1:0], fwd_b[1:0], halted, step_done}
  localparam logic [10:0] V_RUN    = 11'h100;
  localparam logic [10:0] V_STALL  = 11'h640;
  localparam logic [10:0] V_DRAIN  = 11'h640;
  localparam logic [10:0] V_DRBR   = 11'h7C0;
  localparam logic [10:0] V_HALT   = 11'h642;
  localparam logic [10:0] V_HALTSD = 11'h643;
  localparam logic [10:0] V_BRANCH = 11'h1C0;

  pipeline_ctrl #(.DRAIN_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_regwrite_en(ex_regwrite_en),
    .ex_wb_sel(ex_wb_sel), .mem_rd(mem_rd), .mem_regwrite_en(mem_regwrite_en),
    .wb_rd(wb_rd), .wb_regwrite_en(wb_regwrite_en), .wbid_rd(wbid_rd), .wbid_we(wbid_we),
    .pc_sel(pc_sel), .dbg_halt_req(dbg_halt_req), .dbg_step_req(dbg_step_req),
    .stall_if(stall_if), .stall_id(stall_id), .pc_en(pc_en), .flush_id(flush_id),
    .flush_ex(flush_ex), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .halted(halted), .step_done(step_done)
  );

  assign act = {stall_if, stall_id, pc_en, flush_id, flush_ex, fwd_a_sel, fwd_b_sel, halted, step_done};

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, bench did not complete");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [4:0] rs1, rs2, m_rd;
    logic       m_we;
    logic [4:0] w_rd;
    logic       w_we;
    logic [4:0] wi_rd;
    logic       wi_we;
    logic [1:0] ea, eb;
  } fwd_vec_t;

  fwd_vec_t tbl [8];

  function automatic logic [10:0] mk(input logic sif, input logic sid, input logic pcen,
                                     input logic fid, input logic fex, input logic [1:0] fa,
                                     input logic [1:0] fb, input logic hal, input logic sd);
    return {sif, sid, pcen, fid, fex, fa, fb, hal, sd};
  endfunction

  // Reference forwarding: scan producers from nearest to farthest.
  function automatic logic [1:0] ref_fwd(input logic [4:0] src);
    logic [4:0] rd [3];
    logic       we [3];
    rd[0] = mem_rd;  we[0] = mem_regwrite_en;
    rd[1] = wb_rd;   we[1] = wb_regwrite_en;
    rd[2] = wbid_rd; we[2] = wbid_we;
    for (int i = 0; i < 3; i++)
      if (we[i] && rd[i] != 5'd0 && rd[i] == src) return 2'(i + 1);
    return 2'b00;
  endfunction

  task automatic check(input string name, input logic [10:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic cyc(input string name, input logic [10:0] exp);
    #3;
    check(name, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_data();
    id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_rs1 = '0; ex_rs2 = '0; ex_rd = '0; ex_regwrite_en = 0; ex_wb_sel = 0;
    mem_rd = '0; mem_regwrite_en = 0; wb_rd = '0; wb_regwrite_en = 0;
    wbid_rd = '0; wbid_we = 0; pc_sel = 0;
  endtask

  task automatic set_load_use();
    ex_rd = 5'd3; ex_wb_sel = 1; ex_regwrite_en = 1; id_rs2 = 5'd3; id_use_rs2 = 1;
  endtask

  task automatic halt_to_halted();
    dbg_halt_req = 1;
    cyc("halt_req_run", V_RUN);
    for (int i = 0; i < 4; i++) cyc("drain", V_DRAIN);
  endtask

  initial begin
    logic [10:0] exp;
    logic        prev_stall;
    logic        haz, stall;

    tbl[0] = '{5'd5,  5'd0,  5'd5,  1'b1, 5'd5,  1'b1, 5'd0,  1'b0, 2'b01, 2'b00};
    tbl[1] = '{5'd5,  5'd0,  5'd5,  1'b0, 5'd5,  1'b1, 5'd0,  1'b0, 2'b10, 2'b00};
    tbl[2] = '{5'd0,  5'd0,  5'd5,  1'b0, 5'd5,  1'b1, 5'd0,  1'b0, 2'b00, 2'b00};
    tbl[3] = '{5'd7,  5'd7,  5'd7,  1'b0, 5'd7,  1'b0, 5'd7,  1'b1, 2'b11, 2'b11};
    tbl[4] = '{5'd9,  5'd4,  5'd4,  1'b1, 5'd9,  1'b1, 5'd9,  1'b1, 2'b10, 2'b01};
    tbl[5] = '{5'd0,  5'd0,  5'd0,  1'b1, 5'd0,  1'b1, 5'd0,  1'b1, 2'b00, 2'b00};
    tbl[6] = '{5'd3,  5'd3,  5'd2,  1'b1, 5'd3,  1'b0, 5'd3,  1'b1, 2'b11, 2'b11};
    tbl[7] = '{5'd31, 5'd30, 5'd30, 1'b1, 5'd31, 1'b1, 5'd31, 1'b1, 2'b10, 2'b01};

    // Reset with hazard, branch and forwarding matches present: outputs must be quiescent.
    rst = 0; dbg_halt_req = 0; dbg_step_req = 0;
    clear_data();
    set_load_use();
    pc_sel = 1; ex_rs1 = 5'd5; mem_rd = 5'd5; mem_regwrite_en = 1;
    #12;
    check("reset_outputs", V_RUN);
    clear_data();
    @(posedge clk); #1;
    rst = 1;
    cyc("run_idle", V_RUN);

    for (int i = 0; i < 8; i++) begin
      ex_rs1 = tbl[i].rs1; ex_rs2 = tbl[i].rs2;
      mem_rd = tbl[i].m_rd; mem_regwrite_en = tbl[i].m_we;
      wb_rd = tbl[i].w_rd; wb_regwrite_en = tbl[i].w_we;
      wbid_rd = tbl[i].wi_rd; wbid_we = tbl[i].wi_we;
      exp = V_RUN;
      exp[5:4] = tbl[i].ea;
      exp[3:2] = tbl[i].eb;
      cyc($sformatf("fwd_vec%0d", i), exp);
    end
    clear_data();

    // Load-use: exactly one stall cycle even if the stimulus lingers.
    set_load_use();
    cyc("load_use_stall", V_STALL);
    cyc("load_use_once", V_RUN);
    clear_data();
    cyc("after_load_use", V_RUN);

    set_load_use();
    pc_sel = 1;
    cyc("branch_over_load_use", V_BRANCH);
    clear_data();
    cyc("after_branch", V_RUN);

    // Halt with a redirect arriving mid-drain, then release.
    dbg_halt_req = 1;
    cyc("halt_req_run", V_RUN);
    for (int i = 0; i < 4; i++) begin
      pc_sel = (i == 1);
      cyc($sformatf("drain%0d", i), (i == 1) ? V_DRBR : V_DRAIN);
    end
    pc_sel = 0;
    cyc("halted", V_HALT);
    cyc("halted_hold", V_HALT);
    dbg_halt_req = 0;
    cyc("halted_release", V_HALT);
    cyc("run_after_release", V_RUN);

    // Single step from halted.
    halt_to_halted();
    cyc("halted_pre_step", V_HALT);
    dbg_step_req = 1;
    cyc("step_req", V_HALT);
    dbg_step_req = 0;
    cyc("step_open", V_RUN);
    for (int i = 0; i < 4; i++) cyc($sformatf("step_drain%0d", i), V_DRAIN);
    cyc("step_done", V_HALTSD);
    cyc("step_done_once", V_HALT);

    // Step while a load-use hazard sits in ID: stall first, then advance.
    dbg_step_req = 1;
    cyc("step2_req", V_HALT);
    dbg_step_req = 0;
    set_load_use();
    cyc("step_load_use", V_STALL);
    cyc("step_advance", V_RUN);
    clear_data();
    for (int i = 0; i < 4; i++) cyc($sformatf("step2_drain%0d", i), V_DRAIN);
    cyc("step2_done", V_HALTSD);
    dbg_halt_req = 0;
    cyc("step2_exit", V_HALT);
    cyc("run_after_step", V_RUN);

    // Halt request dropped mid-drain: drain completes, one halted cycle, then run.
    dbg_halt_req = 1;
    cyc("abort_req_run", V_RUN);
    cyc("abort_drain0", V_DRAIN);
    dbg_halt_req = 0;
    for (int i = 1; i < 4; i++) cyc($sformatf("abort_drain%0d", i), V_DRAIN);
    cyc("abort_halted", V_HALT);
    cyc("abort_run", V_RUN);

    // Reset asserted at drain count 2.
    dbg_halt_req = 1;
    cyc("rst_req_run", V_RUN);
    cyc("rst_drain4", V_DRAIN);
    cyc("rst_drain3", V_DRAIN);
    set_load_use();
    pc_sel = 1; ex_rs1 = 5'd5; mem_rd = 5'd5; mem_regwrite_en = 1;
    #1 rst = 0;
    #1 check("reset_mid_drain", V_RUN);
    @(posedge clk); #1;
    check("reset_held", V_RUN);
    clear_data();
    dbg_halt_req = 0;
    rst = 1;
    cyc("post_reset_run", V_RUN);
    cyc("post_reset_run2", V_RUN);

    // Randomized RUN-state traffic against the reference model.
    prev_stall = 0;
    for (int n = 0; n < 300; n++) begin
      id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
      id_use_rs1 = 1'($urandom_range(0, 1)); id_use_rs2 = 1'($urandom_range(0, 1));
      ex_rs1 = 5'($urandom_range(0, 3)); ex_rs2 = 5'($urandom_range(0, 3));
      ex_rd = 5'($urandom_range(0, 3));
      ex_regwrite_en = 1'($urandom_range(0, 1)); ex_wb_sel = 1'($urandom_range(0, 1));
      mem_rd = 5'($urandom_range(0, 3)); mem_regwrite_en = 1'($urandom_range(0, 1));
      wb_rd = 5'($urandom_range(0, 3)); wb_regwrite_en = 1'($urandom_range(0, 1));
      wbid_rd = 5'($urandom_range(0, 3)); wbid_we = 1'($urandom_range(0, 1));
      pc_sel = ($urandom_range(0, 3) == 0);
      haz = ex_regwrite_en && ex_wb_sel && ex_rd != 5'd0 &&
            ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
      stall = haz && !pc_sel && !prev_stall;
      exp = mk(stall, stall, !stall || pc_sel, pc_sel, stall || pc_sel,
               ref_fwd(ex_rs1), ref_fwd(ex_rs2), 1'b0, 1'b0);
      cyc($sformatf("random%0d", n), exp);
      prev_stall = stall;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter DRAIN_CYCLES, default 4, meaning the number of bubble cycles needed to empty the EX/MEM/WB/WB_ID stages.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 id_rs1, id_rs2  input  5 each  source register fields of the instruction in IF_ID.
REQ-005 id_use_rs1, id_use_rs2  input  1 each  the IF_ID instruction reads that source.
REQ-006 ex_rs1, ex_rs2  input  5 each  source registers of the instruction in ID_EX.
REQ-007 ex_rd, ex_regwrite_en, ex_wb_sel  input  5/1/1  ID_EX destination, write enable, and load flag (wb_sel=1 means load).
REQ-008 mem_rd, mem_regwrite_en  input  5/1  EX_MEM destination and write enable.
REQ-009 wb_rd, wb_regwrite_en  input  5/1  MEM_WB destination and write enable.
REQ-010 wbid_rd, wbid_we  input  5/1  registered WB_ID destination and write enable.
REQ-011 pc_sel  input  1  branch/jump taken, resolved in EX.
REQ-012 dbg_halt_req  input  1  level halt request.
REQ-013 dbg_step_req  input  1  single-cycle step pulse.
REQ-014 stall_if, stall_id  output  1 each  hold the PC and IF_ID registers.
REQ-015 pc_en  output  1  PC load enable; equals ~stall_if | pc_sel.
REQ-016 flush_id, flush_ex  output  1 each  load a bubble into IF_ID or ID_EX.
REQ-017 fwd_a_sel, fwd_b_sel  output  2 each  EX operand source: 00 register file, 01 EX_MEM ALU out, 10 MEM_WB writeback value, 11 WB_ID value.
REQ-018 halted  output  1  core is halted.
REQ-019 step_done  output  1  one-cycle pulse when a step completes.

Function
REQ-020 Forwarding SHALL be combinational and use nearest-stage priority, checked in order EX_MEM(01), MEM_WB(10), WB_ID(11), else 00.
REQ-021 A forwarding match SHALL require the stage's regwrite_en=1 and a rd equal to the source; rd=0 SHALL never match.
REQ-022 A load-use hazard SHALL be: ex_regwrite_en & ex_wb_sel & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
REQ-023 On a load-use hazard in state RUN, the block SHALL assert stall_if=1, stall_id=1 and flush_ex=1 for exactly one cycle.
REQ-024 On pc_sel=1, the block SHALL assert flush_id=1 and flush_ex=1 in the same cycle.
REQ-025 When pc_sel=1 and a load-use hazard occur together, the branch SHALL take priority: no stall, pc_en=1.
REQ-026 The FSM SHALL have states RUN, DRAIN, HALTED and STEP, encoded in 2 bits, plus a drain counter of clog2(DRAIN_CYCLES+1) bits.
REQ-027 RUN->DRAIN SHALL occur when dbg_halt_req=1; the counter loads DRAIN_CYCLES.
REQ-028 In DRAIN: stall_if=1, stall_id=1, flush_ex=1, and the counter decrements each cycle; when the counter reaches 0 the FSM goes to HALTED.
REQ-029 A pc_sel=1 during DRAIN SHALL still produce pc_en=1 and flush_id=1, so the redirect is not lost.
REQ-030 In HALTED: stall_if=1, stall_id=1, flush_ex=1, halted=1.
REQ-031 In HALTED, dbg_halt_req=0 SHALL cause HALTED->RUN on the next edge.
REQ-032 In HALTED, a dbg_step_req pulse with dbg_halt_req=1 SHALL cause HALTED->STEP.
REQ-033 In STEP, all stalls and flushes SHALL be deasserted for one cycle, so one instruction advances IF_ID->ID_EX; the FSM then enters DRAIN.
REQ-034 If a load-use hazard exists in STEP, the FSM SHALL remain in STEP and apply the REQ-023 stall.
REQ-035 step_done SHALL pulse for one cycle on a DRAIN->HALTED transition that was entered from STEP, tracked by a 1-bit flag.
REQ-036 dbg_halt_req deasserting during DRAIN SHALL NOT abort the drain; the FSM completes it and then goes HALTED->RUN.
REQ-037 dbg_step_req SHALL be ignored outside HALTED.

Reset
REQ-038 While rst=0: state=RUN, counter=0, step flag=0, stall_if=stall_id=flush_id=flush_ex=0, pc_en=1, fwd_*=00, halted=0, step_done=0.
REQ-039 Reset asserted mid-DRAIN or mid-STEP SHALL return the FSM to RUN immediately, asynchronously.
REQ-040 After rst releases, operation SHALL resume on the first rising edge.

Verification
REQ-041 Test forwarding priority: ex_rs1=5, mem_rd=5 and wb_rd=5 with both enables set -> fwd_a_sel=01; then drop mem_regwrite_en -> fwd_a_sel=10; then set ex_rs1=0 -> fwd_a_sel=00.
REQ-042 Test load-use: ex_rd=3, ex_wb_sel=1, ex_regwrite_en=1, id_rs2=3, id_use_rs2=1 -> exactly one cycle of stall_if=stall_id=flush_ex=1, pc_en=0.
REQ-043 Test branch over load-use: REQ-042 stimulus plus pc_sel=1 -> flush_id=flush_ex=1, stall_if=0, pc_en=1.
REQ-044 Test halt: raise dbg_halt_req -> 4 cycles of DRAIN, then halted=1; drop the request -> halted=0 and the state is RUN one edge later.
REQ-045 Test step: while halted, one dbg_step_req pulse -> one cycle with no stalls, 4 drain cycles, then step_done=1 for one cycle and halted=1.
REQ-046 Test reset mid-drain: assert rst=0 at drain count 2 -> all outputs immediately take their REQ-038 values.
